// File: rtl/vector_player_pkg.sv
// Shared types and default sizing for the vector player.
// Holds the FSM state encoding and the default parameter values.
package vector_player_pkg;

    localparam int VP_VEC_W  = 64;
    localparam int VP_DEPTH  = 1024;
    localparam int VP_HOLD_W = 12;
    localparam int VP_RESP_W = 62;
    localparam int VP_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } vp_state_t;

endpackage

// File: rtl/vp_popcount.sv
// Combinational population count of a W-bit word.
// Ports: bits (W) in, count ($clog2(W+1)) out.
module vp_popcount #(
    parameter int W = 62
) (
    input  logic [W-1:0]           bits,
    output logic [$clog2(W+1)-1:0] count
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/vector_player.sv
// Stimulus vector player: plays a loaded memory onto vec_out, one-shot or
// looping, and counts response bit toggles while vectors are live.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ld_en/ld_addr/ld_data    memory load port (ignored while busy)
//   start/stop/loop_mode     run control
//   length, hold             vectors per run, extra hold cycles per vector
//   resp_in                  observed response bus
//   vec_out/vec_valid/vec_idx current stimulus vector and its index
//   busy, done               playing flag, one-shot completion pulse
//   loop_cnt, toggle_cnt     saturating wrap and toggle counters
module vector_player
    import vector_player_pkg::*;
#(
    parameter int VEC_W  = VP_VEC_W,
    parameter int DEPTH  = VP_DEPTH,
    parameter int HOLD_W = VP_HOLD_W,
    parameter int RESP_W = VP_RESP_W,
    parameter int CNT_W  = VP_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [VEC_W-1:0]         ld_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_mode,
    input  logic [$clog2(DEPTH):0]   length,
    input  logic [HOLD_W-1:0]        hold,
    input  logic [RESP_W-1:0]        resp_in,
    output logic [VEC_W-1:0]         vec_out,
    output logic                     vec_valid,
    output logic [$clog2(DEPTH)-1:0] vec_idx,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         loop_cnt,
    output logic [CNT_W-1:0]         toggle_cnt
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PC_W = $clog2(RESP_W + 1);

    vp_state_t         state;
    logic [AW-1:0]     last_idx;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_left;
    logic              loop_q;
    logic              warm;
    logic              seen;
    logic [RESP_W-1:0] resp_q;
    logic [RESP_W-1:0] resp_diff;
    logic [PC_W-1:0]   pc;
    logic [CNT_W:0]    tog_sum;
    logic [CNT_W-1:0]  tog_next;
    logic              start_ok;
    logic              at_last;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;

    logic [VEC_W-1:0]  mem [DEPTH];

    assign busy = (state == ST_PLAY);

    // A start is only taken from a quiescent state with a legal length.
    assign start_ok = start && !stop
                   && (state != ST_PLAY)
                   && (length != '0)
                   && (length <= (AW+1)'(DEPTH));

    assign at_last = (vec_idx == last_idx);

    assign resp_diff = resp_in ^ resp_q;

    vp_popcount #(
        .W(RESP_W)
    ) u_popcount (
        .bits (resp_diff),
        .count(pc)
    );

    assign tog_sum  = {1'b0, toggle_cnt} + (CNT_W+1)'(pc);
    assign tog_next = tog_sum[CNT_W] ? '1 : tog_sum[CNT_W-1:0];

    // Read request: the first fetch waits one warm-up cycle after the
    // start so vector 0 lands two edges after start; later fetches are
    // issued on the last hold cycle of the current vector.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (state == ST_PLAY && !stop) begin
            if (!vec_valid) begin
                rd_en = warm;
            end else if (hold_left == '0) begin
                if (at_last) begin
                    rd_en = loop_q;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = vec_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en && !busy) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out <= '0;
        end else if (rd_en) begin
            vec_out <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            vec_valid  <= 1'b0;
            vec_idx    <= '0;
            done       <= 1'b0;
            loop_cnt   <= '0;
            toggle_cnt <= '0;
            last_idx   <= '0;
            hold_q     <= '0;
            hold_left  <= '0;
            loop_q     <= 1'b0;
            warm       <= 1'b0;
            seen       <= 1'b0;
            resp_q     <= '0;
        end else begin
            done   <= 1'b0;
            resp_q <= resp_in;

            // The first live cycle of a run has no valid predecessor.
            if (vec_valid) begin
                seen <= 1'b1;
                if (seen) begin
                    toggle_cnt <= tog_next;
                end
            end

            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state      <= ST_PLAY;
                        last_idx   <= AW'(length - 1'b1);
                        hold_q     <= hold;
                        loop_q     <= loop_mode;
                        loop_cnt   <= '0;
                        toggle_cnt <= '0;
                        warm       <= 1'b0;
                        seen       <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        state     <= ST_IDLE;
                        vec_valid <= 1'b0;
                    end else if (!vec_valid) begin
                        if (!warm) begin
                            warm <= 1'b1;
                        end else begin
                            vec_valid <= 1'b1;
                            vec_idx   <= '0;
                            hold_left <= hold_q;
                        end
                    end else if (hold_left != '0) begin
                        hold_left <= hold_left - 1'b1;
                    end else if (at_last) begin
                        if (loop_q) begin
                            vec_idx   <= '0;
                            hold_left <= hold_q;
                            if (loop_cnt != '1) begin
                                loop_cnt <= loop_cnt + 1'b1;
                            end
                        end else begin
                            state     <= ST_DONE;
                            vec_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end else begin
                        vec_idx   <= vec_idx + 1'b1;
                        hold_left <= hold_q;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    vec_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_player.sv
// Scoreboard bench for vector_player: directed runs push expected vectors,
// a negedge monitor pops and compares each live output vector.
module tb_vector_player;

    localparam int VEC_W  = 64;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int HOLD_W = 12;
    localparam int RESP_W = 62;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [VEC_W-1:0]  ld_data;
    logic              start;
    logic              stop;
    logic              loop_mode;
    logic [AW:0]       length;
    logic [HOLD_W-1:0] hold;
    logic [RESP_W-1:0] resp_in;
    logic [VEC_W-1:0]  vec_out;
    logic              vec_valid;
    logic [AW-1:0]     vec_idx;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  loop_cnt;
    logic [CNT_W-1:0]  toggle_cnt;

    typedef struct packed {
        logic [VEC_W-1:0] vec;
        logic [AW-1:0]    idx;
    } exp_t;

    exp_t             sb[$];
    logic [VEC_W-1:0] model [DEPTH];
    int               checks   = 0;
    int               failures = 0;

    vector_player #(
        .VEC_W (VEC_W),
        .DEPTH (DEPTH),
        .HOLD_W(HOLD_W),
        .RESP_W(RESP_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .start     (start),
        .stop      (stop),
        .loop_mode (loop_mode),
        .length    (length),
        .hold      (hold),
        .resp_in   (resp_in),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done),
        .loop_cnt  (loop_cnt),
        .toggle_cnt(toggle_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vec_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL vec_extra: got vec=%h idx=%0d, want none",
                         vec_out, vec_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (vec_out !== e.vec || vec_idx !== e.idx) begin
                    failures++;
                    $display("FAIL vec: got vec=%h idx=%0d, want vec=%h idx=%0d",
                             vec_out, vec_idx, e.vec, e.idx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic load(input int addr, input logic [VEC_W-1:0] data,
                        input bit track);
        ld_en   = 1'b1;
        ld_addr = AW'(addr);
        ld_data = data;
        tick();
        ld_en = 1'b0;
        if (track) model[addr] = data;
    endtask

    task automatic expect_run(input int len, input int h, input int n);
        for (int v = 0; v < n; v++) begin
            exp_t e;
            int   ix;
            ix    = (v / (h + 1)) % len;
            e.vec = model[ix];
            e.idx = AW'(ix);
            sb.push_back(e);
        end
    endtask

    task automatic go(input int len, input int h, input bit lp);
        length    = (AW+1)'(len);
        hold      = HOLD_W'(h);
        loop_mode = lp;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vec"},    vec_out,    0);
        chk({tag, "_valid"},  vec_valid,  0);
        chk({tag, "_idx"},    vec_idx,    0);
        chk({tag, "_busy"},   busy,       0);
        chk({tag, "_done"},   done,       0);
        chk({tag, "_loop"},   loop_cnt,   0);
        chk({tag, "_toggle"}, toggle_cnt, 0);
    endtask

    initial begin
        rst       = 1'b1;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        start     = 1'b0;
        stop      = 1'b0;
        loop_mode = 1'b0;
        length    = '0;
        hold      = '0;
        resp_in   = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) load(i, 64'(i + 1), 1'b1);

        // One-shot, four vectors, no hold
        expect_run(4, 0, 4);
        go(4, 0, 1'b0);
        chk("os_busy", busy, 1);
        chk("os_gap0", vec_valid, 0);
        tick();
        chk("os_gap1", vec_valid, 0);
        tick();
        chk("os_first", vec_valid, 1);
        repeat (4) tick();
        chk("os_done", done, 1);
        chk("os_valid_off", vec_valid, 0);
        chk("os_busy_off", busy, 0);
        chk("os_vec_hold", vec_out, 64'd4);
        chk("os_idx_hold", vec_idx, 3);
        tick();
        chk("os_done_pulse", done, 0);
        chk("os_vec_hold2", vec_out, 64'd4);

        // Loop with hold=2, stop after wrap 3
        expect_run(2, 2, 19);
        go(2, 2, 1'b1);
        chk("lp_cnt_clr", loop_cnt, 0);
        repeat (20) tick();
        chk("lp_cnt3", loop_cnt, 3);
        chk("lp_idx0", vec_idx, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("lp_stop_valid", vec_valid, 0);
        chk("lp_stop_busy", busy, 0);
        chk("lp_stop_done", done, 0);
        chk("lp_cnt_kept", loop_cnt, 3);
        tick();
        chk("lp_no_done", done, 0);

        // Toggle count: 0/ones alternating over 5 live cycles
        expect_run(5, 0, 5);
        go(5, 0, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            resp_in = (k % 2 == 1) ? '1 : '0;
        end
        tick();
        chk("tog_done", done, 1);
        chk("tog_248", toggle_cnt, 248);

        // Toggle saturation: 5 x 62 = 310 exceeds 8-bit range
        expect_run(6, 0, 6);
        go(6, 0, 1'b0);
        chk("tog_clr", toggle_cnt, 0);
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            resp_in = (k % 2 == 1) ? '1 : '0;
        end
        tick();
        chk("tog_sat", toggle_cnt, 255);
        resp_in = '0;

        // Rejected starts
        go(0, 0, 1'b0);
        chk("len0_busy", busy, 0);
        stop = 1'b1;
        go(4, 0, 1'b0);
        stop = 1'b0;
        chk("startstop_busy", busy, 0);
        go(17, 0, 1'b0);
        chk("len17_busy", busy, 0);
        tick();
        chk("rej_no_valid", vec_valid, 0);

        // Loads while busy are dropped
        expect_run(2, 0, 2);
        go(2, 0, 1'b0);
        load(0, 64'hDEAD, 1'b0);
        load(1, 64'hBEEF, 1'b0);
        repeat (2) tick();
        chk("bw_done", done, 1);
        expect_run(2, 0, 2);
        go(2, 0, 1'b0);
        repeat (4) tick();
        chk("bw_done2", done, 1);
        chk("bw_vec1", vec_out, 64'd2);

        // Full depth, one-shot then loop
        expect_run(16, 0, 16);
        go(16, 0, 1'b0);
        repeat (18) tick();
        chk("full_done", done, 1);
        chk("full_idx", vec_idx, 15);
        chk("full_vec", vec_out, 64'd16);
        expect_run(16, 0, 17);
        go(16, 0, 1'b1);
        repeat (18) tick();
        chk("full_wrap_cnt", loop_cnt, 1);
        chk("full_wrap_idx", vec_idx, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("full_stop", vec_valid, 0);

        // Loop counter saturation with length 1
        expect_run(1, 0, 299);
        go(1, 0, 1'b1);
        repeat (300) tick();
        chk("lp_sat", loop_cnt, 255);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("lp_sat_stop", busy, 0);

        // Write then start on the very next edge
        load(0, 64'hA5A5, 1'b1);
        expect_run(1, 0, 1);
        go(1, 0, 1'b0);
        repeat (3) tick();
        chk("wr_done", done, 1);
        chk("wr_vec", vec_out, 64'hA5A5);

        // Reset while vector 2 is showing
        expect_run(4, 0, 3);
        go(4, 0, 1'b0);
        repeat (4) tick();
        chk("rr_idx2", vec_idx, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midrst");
        expect_run(4, 0, 4);
        go(4, 0, 1'b0);
        repeat (6) tick();
        chk("rr_done", done, 1);
        chk("rr_vec", vec_out, 64'd4);

        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
